// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point divider.
// Contents:
//   - default exponent/fraction widths and the bias, word width and all-ones exponent
//     derived from them
//   - the divider state enum
//   - builders for the qNaN/inf/zero constants, sized at run time by (exp_w, man_w) and
//     returned in a MAX_W-bit container that the caller truncates
//   - the operand classifier (zero / inf / NaN)
package fp_pkg;

  localparam int unsigned DEF_EXP_W  = 8;
  localparam int unsigned DEF_MAN_W  = 23;
  localparam int unsigned MAX_W      = 64;
  localparam int unsigned FP_BIAS    = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int unsigned FP_W       = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int unsigned FP_EXP_MAX = (1 << DEF_EXP_W) - 1;

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} fp_state_e;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int unsigned fp_exp_max(input int unsigned exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic [MAX_W-1:0] fp_inf(input logic sign, input int unsigned exp_w,
                                              input int unsigned man_w);
    logic [MAX_W-1:0] w;
    w = MAX_W'(sign);
    w = (w << exp_w) | ((MAX_W'(1) << exp_w) - MAX_W'(1));
    return w << man_w;
  endfunction

  function automatic logic [MAX_W-1:0] fp_zero(input logic sign, input int unsigned exp_w,
                                               input int unsigned man_w);
    return MAX_W'(sign) << (exp_w + man_w);
  endfunction

  // Positive quiet NaN: all-ones exponent, fraction MSB set.
  function automatic logic [MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                               input int unsigned man_w);
    return fp_inf(1'b0, exp_w, man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

  // Exponent field 0 is zero; subnormals are flushed by this rule.
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_nz);
    fp_class_t c;
    c.is_zero = exp_zero;
    c.is_inf  = exp_ones & ~frac_nz;
    c.is_nan  = exp_ones & frac_nz;
    return c;
  endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// One radix-2 restoring division step on the mantissa remainder.
// Ports:
//   r_i      remainder before the step (MAN_W+2 bits)
//   mb_i     divisor mantissa {1, fraction} (MAN_W+1 bits)
//   q_bit_o  quotient bit produced by this step
//   r_next_o remainder after the conditional subtract and left shift
module fp_div_mant_iter #(
  parameter int unsigned MAN_W = 23
) (
  input  logic [MAN_W+1:0] r_i,
  input  logic [MAN_W:0]   mb_i,
  output logic             q_bit_o,
  output logic [MAN_W+1:0] r_next_o
);

  logic [MAN_W+1:0] diff;

  always_comb begin
    q_bit_o = (r_i >= {1'b0, mb_i});
    diff    = q_bit_o ? (r_i - {1'b0, mb_i}) : r_i;
    // diff is always below mb, so the shift cannot lose its top bit.
    r_next_o = {diff[MAN_W:0], 1'b0};
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754-style divider: one quotient bit per clock.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake; in_ready high only in idle
//   a, b                    dividend and divisor (W = 1+EXP_W+MAN_W bits)
//   out_valid / out_ready   result handshake; result and flags held until taken
//   result                  quotient
//   div_by_zero             finite nonzero a over zero b
//   invalid                 0/0, inf/inf or any NaN operand
// Build option: define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise truncate.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         div_by_zero,
  output logic         invalid
);

  localparam int unsigned CntW = $clog2(MAN_W + 3);
  localparam logic [CntW-1:0] CntInit = CntW'(MAN_W + 2);
  localparam logic signed [EXP_W+1:0] Bias    = (EXP_W + 2)'(fp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] ExpMax  = (EXP_W + 2)'(fp_exp_max(EXP_W));
  localparam logic signed [EXP_W+1:0] ExpOne  = 1;
  localparam logic signed [EXP_W+1:0] ExpZero = '0;

  fp_state_e state_q, state_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [MAN_W+2:0]        quo_q, quo_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]            result_q, result_d;
  logic                    dbz_q, dbz_d, inv_q, inv_d, out_valid_q, out_valid_d;

  logic             sa, sb, sign_in;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_t        ca, cb;
  logic             special, spec_dbz, spec_inv;
  logic [W-1:0]     spec_res, norm_res;
  logic             q_bit;
  logic [MAN_W+1:0] rem_next;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sign_in      = sa ^ sb;
  assign ca           = fp_classify(ea == '0, &ea, |fa);
  assign cb           = fp_classify(eb == '0, &eb, |fb);

  // Special operands bypass the iteration; checks run in priority order.
  always_comb begin
    special  = 1'b1;
    spec_dbz = 1'b0;
    spec_inv = 1'b0;
    spec_res = '0;
    if (ca.is_nan || cb.is_nan) begin
      spec_res = W'(fp_qnan(EXP_W, MAN_W));
      spec_inv = 1'b1;
    end else if ((ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      spec_res = W'(fp_qnan(EXP_W, MAN_W));
      spec_inv = 1'b1;
    end else if (cb.is_zero && !ca.is_inf) begin
      spec_res = W'(fp_inf(sign_in, EXP_W, MAN_W));
      spec_dbz = 1'b1;
    end else if (ca.is_inf) begin
      spec_res = W'(fp_inf(sign_in, EXP_W, MAN_W));
    end else if (cb.is_inf || ca.is_zero) begin
      spec_res = W'(fp_zero(sign_in, EXP_W, MAN_W));
    end else begin
      special = 1'b0;
    end
  end

  fp_div_mant_iter #(
    .MAN_W(MAN_W)
  ) u_iter (
    .r_i     (rem_q),
    .mb_i    (mb_q),
    .q_bit_o (q_bit),
    .r_next_o(rem_next)
  );

  logic [MAN_W-1:0]        frac, frac_r;
  logic signed [EXP_W+1:0] exp_n, exp_r;
`ifdef FP_DIV_ROUND_EN
  logic guard, sticky, carry;
`endif

  // Normalise the MAN_W+3 quotient bits, round, then range-check the exponent.
  always_comb begin
    frac  = quo_q[MAN_W:1];
    exp_n = exp_q - ExpOne;
    if (quo_q[MAN_W+2]) begin
      frac  = quo_q[MAN_W+1:2];
      exp_n = exp_q;
    end
`ifdef FP_DIV_ROUND_EN
    guard  = quo_q[MAN_W+2] ? quo_q[1] : quo_q[0];
    sticky = (|rem_q) | (quo_q[MAN_W+2] & quo_q[0]);
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
    // A carry-out leaves frac_r at zero and bumps the exponent.
    exp_r = carry ? (exp_n + ExpOne) : exp_n;
`else
    frac_r = frac;
    exp_r  = exp_n;
`endif
    if (exp_r >= ExpMax) begin
      norm_res = W'(fp_inf(sign_q, EXP_W, MAN_W));
    end else if (exp_r <= ExpZero) begin
      norm_res = W'(fp_zero(sign_q, EXP_W, MAN_W));
    end else begin
      norm_res = {sign_q, exp_r[EXP_W-1:0], frac_r};
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mb_d        = mb_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    inv_d       = inv_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = sign_in;
          if (special) begin
            result_d = spec_res;
            dbz_d    = spec_dbz;
            inv_d    = spec_inv;
            state_d  = StDone;
          end else begin
            exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + Bias;
            mb_d    = {1'b1, fb};
            rem_d   = {2'b01, fa};
            quo_d   = '0;
            cnt_d   = CntInit;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d = rem_next;
        quo_d = {quo_q[MAN_W+1:0], q_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = StNorm;
      end
      StNorm: begin
        result_d = norm_res;
        state_d  = StDone;
      end
      StDone: begin
        // out_valid rises one cycle after DONE is entered so it comes straight from a flop.
        if (out_valid_q && out_ready) begin
          dbz_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = StIdle;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int W        = 1 + EXP_W + MAN_W;
  localparam int BIAS     = 127;
  localparam int EMAX     = 255;
  localparam int LAT_NORM = MAN_W + 5;
  localparam int LAT_SPEC = 1;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic         div_by_zero, invalid;

  fp_div_seq #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_by_zero(div_by_zero),
    .invalid    (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [W-1:0] res;
    logic         dbz;
    logic         inv;
    logic         special;
  } mres_t;

  typedef struct {
    mres_t m;
    int    due;
    bit    seen;
  } pend_t;

  pend_t expq[$];
  bit    busy = 1'b0;
  mres_t mm;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endfunction

  // Reference: exact quotient of the mantissas by integer division, then range rules.
  function automatic mres_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    mres_t  m;
    logic   sx, sy, s;
    int     ex, ey, e;
    longint fx, fy, mx, my, num, q;
    bit     xz, xi, xn, yz, yi, yn;
`ifdef FP_DIV_ROUND_EN
    longint rr;
`endif
    sx = x[W-1];
    sy = y[W-1];
    ex = int'(x[W-2:MAN_W]);
    ey = int'(y[W-2:MAN_W]);
    fx = longint'(x[MAN_W-1:0]);
    fy = longint'(y[MAN_W-1:0]);
    s  = sx ^ sy;
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == EMAX) && (fx == 0);
    yi = (ey == EMAX) && (fy == 0);
    xn = (ex == EMAX) && (fx != 0);
    yn = (ey == EMAX) && (fy != 0);
    m  = '0;
    m.special = 1'b1;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      m.res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      m.inv = 1'b1;
    end else if (yz && !xi) begin
      m.res = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      m.dbz = 1'b1;
    end else if (xi) begin
      m.res = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (yi || xz) begin
      m.res = {s, {(W - 1){1'b0}}};
    end else begin
      m.special = 1'b0;
      mx = (64'sd1 <<< MAN_W) | fx;
      my = (64'sd1 <<< MAN_W) | fy;
      e  = ex - ey + BIAS;
      if (mx >= my) begin
        num = mx <<< MAN_W;
      end else begin
        num = mx <<< (MAN_W + 1);
        e   = e - 1;
      end
      q = num / my;
`ifdef FP_DIV_ROUND_EN
      rr = num % my;
      if ((2 * rr > my) || ((2 * rr == my) && (q % 2 == 1))) q = q + 1;
      if (q == (64'sd1 <<< (MAN_W + 1))) begin
        q = q >>> 1;
        e = e + 1;
      end
`endif
      if (e >= EMAX) m.res = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (e <= 0) m.res = {s, {(W - 1){1'b0}}};
      else m.res = {s, e[EXP_W-1:0], q[MAN_W-1:0]};
    end
    return m;
  endfunction

  // Compare process: every negedge, against the pending-result queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      busy = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_result", result, 0);
      check("rst_div_by_zero", div_by_zero, 0);
      check("rst_invalid", invalid, 0);
    end else begin
      check("in_ready", in_ready, !busy);
      if (out_valid) begin
        if (expq.size() == 0) begin
          fail_now("spurious_out_valid", "out_valid=1 with no operation pending, required 0");
        end else begin
          if (!expq[0].seen) begin
            check("latency", cyc, expq[0].due);
            expq[0].seen = 1'b1;
          end
          check("result", result, expq[0].m.res);
          check("div_by_zero", div_by_zero, expq[0].m.dbz);
          check("invalid", invalid, expq[0].m.inv);
          if (out_ready) begin
            void'(expq.pop_front());
            busy = 1'b0;
          end
        end
      end else if (expq.size() > 0 && !expq[0].seen && cyc > expq[0].due) begin
        fail_now("late_result", "out_valid=0 past due cycle, required 1");
        expq[0].seen = 1'b1;
      end
      if (in_valid && in_ready) begin
        pend_t p;
        p.m    = model(a, b);
        p.due  = cyc + 1 + (p.m.special ? LAT_SPEC : LAT_NORM);
        p.seen = 1'b0;
        expq.push_back(p);
        busy = 1'b1;
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept_timeout", "in_ready=0 for 200 cycles, required 1");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("result_timeout", "out_valid=0 for 100 cycles, required 1");
    repeat (hold) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      a        = $urandom;
      b        = $urandom;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    out_ready = (hold == 0);
    issue(x, y);
    wait_result(hold);
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    s = 1'($urandom);
    f = MAN_W'($urandom);
    case ($urandom_range(0, 11))
      0: e = '0;
      1: begin e = '1; f = '0; end
      2: begin e = '1; if (f == '0) f = 1; end
      3: e = EXP_W'($urandom_range(1, EMAX - 1));
      4: begin e = EXP_W'($urandom_range(BIAS - 5, BIAS + 5)); f = '0; end
      default: e = EXP_W'($urandom_range(BIAS - 20, BIAS + 20));
    endcase
    return {s, e, f};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_cmp++;
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    mres_t pm;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model to hand-computed values.
    pm = model(32'h40C00000, 32'h40000000);
    check("pin_6_div_2", {pm.res, pm.dbz, pm.inv}, {32'h40400000, 2'b00});
    pm = model(32'h3F800000, 32'h40400000);
`ifdef FP_DIV_ROUND_EN
    check("pin_1_div_3", pm.res, 32'h3EAAAAAB);
`else
    check("pin_1_div_3", pm.res, 32'h3EAAAAAA);
`endif
    pm = model(32'h3F800000, 32'h00000000);
    check("pin_1_div_0", {pm.res, pm.dbz, pm.inv}, {32'h7F800000, 2'b10});
    pm = model(32'h00000000, 32'h00000000);
    check("pin_0_div_0", {pm.res, pm.dbz, pm.inv}, {32'h7FC00000, 2'b01});
    pm = model(32'h7F000000, 32'h3E800000);
    check("pin_overflow", pm.res, 32'h7F800000);
    pm = model(32'h00800000, 32'h7F000000);
    check("pin_underflow", pm.res, 32'h00000000);
    pm = model(32'h41200000, 32'h40A00000);
    check("pin_10_div_5", pm.res, 32'h40000000);

    // Directed vectors through the DUT.
    run_op(32'h40C00000, 32'h40000000, 0);
    run_op(32'h3F800000, 32'h40400000, 0);
    run_op(32'h3F800000, 32'h00000000, 0);
    run_op(32'h00000000, 32'h00000000, 0);
    run_op(32'h7F000000, 32'h3E800000, 0);
    run_op(32'h00800000, 32'h7F000000, 0);
    run_op(32'hFF800000, 32'h00000000, 0);
    run_op(32'hC0C00000, 32'h7F800000, 0);

    // Backpressure with ignored in_valid pulses.
    run_op(32'h40C00000, 32'h40000000, 10);
    run_op(32'h3F800000, 32'h00000000, 10);

    // Reset in the middle of the iteration.
    out_ready = 1'b1;
    issue(32'h3F800000, 32'h40400000);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    run_op(32'h41200000, 32'h40A00000, 0);

    // Randomised traffic with idle gaps and occasional backpressure.
    for (int i = 0; i < 60; i++) begin
      int hold, gap;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      gap  = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      run_op(rand_operand(), rand_operand(), hold);
    end

    repeat (5) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
